// File: rtl/count_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : count_cmd_seq
//  Description : Command sequencer for a saturating up/down counter.
//                Accepts opcode/operand commands over valid/ready, queues
//                them in a small FIFO, and replays each one as registered
//                per-cycle counter strobes (reset, load, set-max, up, down)
//                plus the data value. At most one strobe is high per cycle.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                cmd_valid/ready    - command handshake
//                cmd_op, cmd_data   - opcode (3 bits) and N-bit operand
//                cnt_rst, up, down,
//                load, max          - counter control strobes (registered)
//                data_out           - counter data input (registered)
//                busy               - FSM running or commands queued
//                fifo_count         - number of queued commands
//  Revision    : 1.0 - initial release
// ============================================================================
module count_cmd_seq #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [N-1:0]             cmd_data,
    output logic                     cnt_rst,
    output logic                     up,
    output logic                     down,
    output logic                     load,
    output logic                     max,
    output logic [N-1:0]             data_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] c_OP_RST    = 3'd1;
    localparam logic [2:0] c_OP_LOAD   = 3'd2;
    localparam logic [2:0] c_OP_SETMAX = 3'd3;
    localparam logic [2:0] c_OP_UP     = 3'd4;
    localparam logic [2:0] c_OP_DOWN   = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // FSM and output registers
    state_t         state_q, state_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           cnt_rst_q, cnt_rst_d;
    logic           up_q, up_d;
    logic           down_q, down_d;
    logic           load_q, load_d;
    logic           max_q, max_d;
    logic [N-1:0]   data_q, data_d;

    // FIFO storage and pointers; entries are {op, data}
    logic [N+2:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           w_push;
    logic           w_pop;
    logic           w_empty;
    logic [2:0]     w_head_op;
    logic [N-1:0]   w_head_data;

    assign w_empty     = (count_q == '0);
    // Full blocks acceptance even if the head is popped on the same edge.
    assign cmd_ready   = (count_q != CW'(DEPTH));
    assign w_push      = cmd_valid & cmd_ready;
    assign w_head_op   = mem_q[rd_ptr_q][N+2:N];
    assign w_head_data = mem_q[rd_ptr_q][N-1:0];

    // A new command is issued when idle or on the last cycle of a repeat.
    assign w_pop = !w_empty && ((state_q == S_IDLE) || (rem_q == '0));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        cnt_rst_d = cnt_rst_q;
        up_d      = up_q;
        down_d    = down_q;
        load_d    = load_q;
        max_d     = max_q;
        data_d    = data_q;

        if (w_pop) begin
            cnt_rst_d = 1'b0;
            up_d      = 1'b0;
            down_d    = 1'b0;
            load_d    = 1'b0;
            max_d     = 1'b0;
            data_d    = '0;
            rem_d     = '0;
            state_d   = S_RUN;
            case (w_head_op)
                c_OP_RST:    cnt_rst_d = 1'b1;
                c_OP_LOAD: begin
                    load_d = 1'b1;
                    data_d = w_head_data;
                end
                c_OP_SETMAX: begin
                    max_d  = 1'b1;
                    data_d = w_head_data;
                end
                // rem counts the extra cycles, so operand d gives d+1 cycles
                c_OP_UP: begin
                    up_d  = 1'b1;
                    rem_d = w_head_data;
                end
                c_OP_DOWN: begin
                    down_d = 1'b1;
                    rem_d  = w_head_data;
                end
                default: ; // NOP and reserved: one RUN cycle, strobes low
            endcase
        end else if ((state_q == S_RUN) && (rem_q != '0)) begin
            rem_d = rem_q - N'(1);
        end else begin
            cnt_rst_d = 1'b0;
            up_d      = 1'b0;
            down_d    = 1'b0;
            load_d    = 1'b0;
            max_d     = 1'b0;
            data_d    = '0;
            rem_d     = '0;
            state_d   = S_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            cnt_rst_q <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            load_q    <= 1'b0;
            max_q     <= 1'b0;
            data_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            cnt_rst_q <= cnt_rst_d;
            up_q      <= up_d;
            down_q    <= down_d;
            load_q    <= load_d;
            max_q     <= max_d;
            data_q    <= data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            if (w_push) begin
                mem_q[wr_ptr_q] <= {cmd_op, cmd_data};
            end
        end
    end

    assign cnt_rst    = cnt_rst_q;
    assign up         = up_q;
    assign down       = down_q;
    assign load       = load_q;
    assign max        = max_q;
    assign data_out   = data_q;
    assign busy       = (state_q == S_RUN) || !w_empty;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_cmd_seq
//  Description : Self-checking bench for count_cmd_seq. Each accepted
//                command schedules its expected per-cycle output vectors in
//                a scoreboard queue; every cycle the head entry due for that
//                cycle is popped and compared, otherwise all-zero is expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_cmd_seq;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [N-1:0] cmd_data = '0;
    logic         cnt_rst, up, down, load, max;
    logic [N-1:0] data_out;
    logic         busy;
    logic [$clog2(DEPTH):0] fifo_count;

    count_cmd_seq #(.N(N), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cnt_rst    (cnt_rst),
        .up         (up),
        .down       (down),
        .load       (load),
        .max        (max),
        .data_out   (data_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Expected output vector {cnt_rst, up, down, load, max, data[3:0]}
    typedef struct {
        int unsigned e;
        logic [8:0]  v;
    } exp_t;

    exp_t        sb[$];      // expected active cycles, in edge order
    int unsigned pend[$];    // start edges of queued (not yet issued) commands
    int unsigned edge_n = 0;
    int unsigned next_free = 0;
    bit          acc_flag = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h, want %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Reference: track acceptance and schedule the expected strobe trace.
    always @(posedge clk) begin
        int unsigned s, len;
        logic [8:0]  v;
        bit          acc;
        edge_n++;
        acc = 1'b0;
        if (rst) begin
            sb.delete();
            pend.delete();
            next_free = 0;
        end else begin
            acc = cmd_valid && (pend.size() < DEPTH);
            while (pend.size() > 0 && pend[0] <= edge_n) void'(pend.pop_front());
            if (acc) begin
                s = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
                len = 1;
                v = '0;
                case (cmd_op)
                    3'd1: v = 9'b1_0000_0000;
                    3'd2: v = {5'b00010, cmd_data};
                    3'd3: v = {5'b00001, cmd_data};
                    3'd4: begin v = 9'b0_1000_0000; len = cmd_data + 1; end
                    3'd5: begin v = 9'b0_0100_0000; len = cmd_data + 1; end
                    default: v = '0;
                endcase
                for (int i = 0; i < int'(len); i++) sb.push_back('{s + i, v});
                pend.push_back(s);
                next_free = s + len;
            end
        end
        acc_flag = acc;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [8:0] exp_v, obs_v;
        bit run;
        if (edge_n > 0) begin
            exp_v = '0;
            run = 1'b0;
            if (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_v = sb[0].v;
                void'(sb.pop_front());
                run = 1'b1;
            end
            obs_v = {cnt_rst, up, down, load, max, data_out};
            chk("outputs",    32'(obs_v), 32'(exp_v));
            chk("fifo_count", 32'(fifo_count), pend.size());
            chk("cmd_ready",  32'(cmd_ready), 32'(pend.size() < DEPTH));
            chk("busy",       32'(busy), 32'(run || pend.size() > 0));
            chk("one_strobe", 32'($countones(obs_v[8:4]) > 1), 0);
        end
    end

    // Present one command from a negedge and hold it until accepted.
    task automatic send(input logic [2:0] op, input logic [N-1:0] d);
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (acc_flag) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && pend.size() == 0) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        chk("idle_timeout", 1, 0);
    endtask

    initial begin
        // Reset held for two edges
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single LOAD
        send(3'd2, 4'b0101);
        wait_idle();

        // UP 3 chained to DOWN 0
        send(3'd4, 4'd3);
        send(3'd5, 4'd0);
        wait_idle();

        // Longest repeat, with the FIFO driven to full behind it
        send(3'd4, 4'hF);
        send(3'd0, 4'd0);
        send(3'd2, 4'd1);
        send(3'd1, 4'd0);
        send(3'd5, 4'd1);
        send(3'd3, 4'd7);
        wait_idle();

        // Reset on the third up cycle with two commands queued
        send(3'd4, 4'd7);
        send(3'd2, 4'd3);
        send(3'd3, 4'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // NOP and reserved opcodes, then SETMAX
        send(3'd0, 4'd0);
        send(3'd6, 4'd9);
        send(3'd7, 4'd5);
        send(3'd3, 4'b1010);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/count_cmd_seq.md
# count_cmd_seq

Command sequencer that sits directly upstream of the saturating up/down counter. It accepts opcode/operand commands over a valid/ready handshake and buffers them in a small FIFO. It replays each command as the counter's per-cycle control strobes (reset, load, set-max, up, down) plus the data value. At most one strobe is active in any cycle, so the counter's one-hot select and max-register load are never driven ambiguously.

## Interface
Parameters:
- N, 4, data width; equals the downstream counter width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  FIFO can accept; high when fifo_count < DEPTH.
- cmd_op  in  3  opcode.
- cmd_data  in  N  operand.
- cnt_rst  out  1  drives counter reset.
- up  out  1  drives counter up.
- down  out  1  drives counter down.
- load  out  1  drives counter load.
- max  out  1  drives counter max-register load.
- data_out  out  N  drives counter data input.
- busy  out  1  high when the FSM is in RUN or the FIFO is non-empty.
- fifo_count  out  clog2(DEPTH)+1  number of queued commands.

## Operation
Opcodes:
- 0 NOP: one idle cycle.
- 1 RST: cnt_rst=1 for 1 cycle.
- 2 LOAD: load=1 and data_out=cmd_data for 1 cycle.
- 3 SETMAX: max=1 and data_out=cmd_data for 1 cycle.
- 4 UP: up=1 for cmd_data+1 consecutive cycles (range 1..2^N).
- 5 DOWN: down=1 for cmd_data+1 consecutive cycles.
- 6, 7 reserved: executed as NOP.

FIFO behaviour:
- A command is pushed on an edge where cmd_valid & cmd_ready.
- Commands are popped in order.
- There is no bypass path: a command pushed into an empty FIFO still passes through it.
- When full, cmd_ready is low even if a pop occurs on the same edge.
- A push and a pop on the same edge leave fifo_count unchanged.

FSM states are IDLE and RUN, with an N-bit remaining-cycles counter rem. On each edge:
- If (IDLE, or RUN with rem==0) and the FIFO is non-empty: pop the head, load the registered outputs for that opcode, set rem = cmd_data for UP/DOWN and 0 otherwise, and go to RUN.
- Else if RUN and rem>0: decrement rem and hold the outputs.
- Else: clear all strobes, set data_out=0, and go to IDLE.

Output rules:
- All strobes and data_out are registered.
- At most one of cnt_rst/up/down/load/max is high in any cycle.
- data_out is 0 except during LOAD and SETMAX.
- NOP and reserved opcodes occupy RUN for one cycle with all strobes low.

## Timing
- Reset: on an edge with rst=1, all outputs become 0, the FIFO is emptied, fifo_count=0, the FSM goes to IDLE, and rem=0. After reset cmd_ready=1 and busy=0. rst overrides a simultaneous push.
- Reset mid-operation: outputs clear on that edge; the in-progress repeat and all queued commands are discarded. The controller's own reset does not pulse cnt_rst.
- Latency: a command pushed at edge E into an empty FIFO with the FSM idle drives outputs in the cycle after edge E+1.
- Back-to-back queued commands execute on consecutive cycles with no idle gap.
- UP/DOWN with cmd_data=2^N-1 holds its strobe for 2^N cycles; rem never wraps.
- fifo_count and cmd_ready update on the same edge as the push or pop.

## Test plan
- Reset: rst high for 2 cycles -> all strobes 0, data_out=0000, cmd_ready=1, fifo_count=0, busy=0.
- LOAD: push op=2, data=0101 into an idle block at edge 1 -> after edge 2, load=1 and data_out=0101 for exactly one cycle, then all outputs 0 and busy=0.
- Repeat plus chaining: push UP data=3 then DOWN data=0 -> up high for exactly 4 cycles, down high for 1 cycle immediately after with no gap; no cycle has two strobes high.
- FIFO full: during UP data=1111 (16 cycles), push 5 commands at 1 per cycle -> first 4 accepted, fifo_count=4, cmd_ready=0, fifth held until a pop; after the pop it is accepted and fifo_count returns to 4.
- Reset mid-UP: assert rst on the 3rd up cycle with 2 commands queued -> up=0 after that edge, fifo_count=0, and the queued commands never appear.
- NOP and reserved: push op=0, 6, 7, then SETMAX data=1010 -> 3 idle cycles, then max=1 with data_out=1010 for 1 cycle.
